// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Memory-access pipeline stage with an internal word-addressed
//               RAM of configurable latency and a registered write-back bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] read_data2_in,
    input  logic [3:0]  opcode_in,
    input  logic [3:0]  regdst_in,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_regdst,
    output logic        wb_en,
    output logic [3:0]  wb_opcode,
    output logic        misalign
);

    localparam int         c_DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] c_OP_LOAD  = 4'b0100;
    localparam logic [3:0] c_OP_STORE = 4'b0101;
    localparam logic [3:0] c_CNT_LOAD = 4'(MEM_LAT - 1);
    localparam bit         c_MULTI    = (MEM_LAT > 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                r_stall, w_stall_nxt;
    logic [31:0]         r_wb_data, w_wb_data_nxt;
    logic [3:0]          r_wb_regdst, w_wb_regdst_nxt;
    logic [3:0]          r_wb_opcode, w_wb_opcode_nxt;
    logic                r_wb_en, w_wb_en_nxt;
    logic                r_misalign, w_misalign_nxt;

    // Operation parked while the RAM access is in flight
    logic                r_lat_is_load;
    logic [ADDR_W-1:0]   r_lat_idx;
    logic [31:0]         r_lat_data;
    logic [3:0]          r_lat_opcode;
    logic [3:0]          r_lat_regdst;
    logic                w_capture;

    logic [31:0]         r_mem [c_DEPTH];
    logic [ADDR_W-1:0]   w_in_idx;
    logic [ADDR_W-1:0]   w_mem_idx;
    logic [31:0]         w_rdata;
    logic [31:0]         w_mem_wdata;
    logic                w_mem_we;
    logic                w_is_mem;
    logic                w_misal;
    logic                w_no_wb;

    assign w_in_idx  = alu_out_in[ADDR_W+1:2];
    assign w_is_mem  = (opcode_in == c_OP_LOAD) || (opcode_in == c_OP_STORE);
    assign w_misal   = (alu_out_in[1:0] != 2'b00);
    assign w_no_wb   = (opcode_in == 4'b0110) || (opcode_in == 4'b0111) ||
                       (opcode_in == 4'b1010);
    assign w_mem_idx = (r_state == S_WAIT) ? r_lat_idx : w_in_idx;
    assign w_rdata   = r_mem[w_mem_idx];

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_stall_nxt     = r_stall;
        w_wb_data_nxt   = r_wb_data;
        w_wb_regdst_nxt = r_wb_regdst;
        w_wb_opcode_nxt = r_wb_opcode;
        w_wb_en_nxt     = 1'b0;
        w_misalign_nxt  = 1'b0;
        w_capture       = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_wdata     = read_data2_in;

        case (r_state)
            S_IDLE: begin
                if (valid_in) begin
                    if (w_is_mem && !w_misal && c_MULTI) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_CNT_LOAD;
                        w_stall_nxt = 1'b1;
                        w_capture   = 1'b1;
                    end else begin
                        w_wb_regdst_nxt = regdst_in;
                        w_wb_opcode_nxt = opcode_in;
                        if (w_is_mem && w_misal) begin
                            w_misalign_nxt = 1'b1;
                        end else if (opcode_in == c_OP_LOAD) begin
                            w_wb_data_nxt = w_rdata;
                            w_wb_en_nxt   = 1'b1;
                        end else if (opcode_in == c_OP_STORE) begin
                            w_mem_we = 1'b1;
                        end else if (!w_no_wb) begin
                            w_wb_data_nxt = alu_out_in;
                            w_wb_en_nxt   = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt     = S_IDLE;
                    w_stall_nxt     = 1'b0;
                    w_wb_regdst_nxt = r_lat_regdst;
                    w_wb_opcode_nxt = r_lat_opcode;
                    if (r_lat_is_load) begin
                        w_wb_data_nxt = w_rdata;
                        w_wb_en_nxt   = 1'b1;
                    end else begin
                        w_mem_we    = 1'b1;
                        w_mem_wdata = r_lat_data;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_stall       <= 1'b0;
            r_wb_data     <= 32'd0;
            r_wb_regdst   <= 4'd0;
            r_wb_opcode   <= 4'd0;
            r_wb_en       <= 1'b0;
            r_misalign    <= 1'b0;
            r_lat_is_load <= 1'b0;
            r_lat_idx     <= '0;
            r_lat_data    <= 32'd0;
            r_lat_opcode  <= 4'd0;
            r_lat_regdst  <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stall     <= w_stall_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_wb_regdst <= w_wb_regdst_nxt;
            r_wb_opcode <= w_wb_opcode_nxt;
            r_wb_en     <= w_wb_en_nxt;
            r_misalign  <= w_misalign_nxt;
            if (w_capture) begin
                r_lat_is_load <= (opcode_in == c_OP_LOAD);
                r_lat_idx     <= w_in_idx;
                r_lat_data    <= read_data2_in;
                r_lat_opcode  <= opcode_in;
                r_lat_regdst  <= regdst_in;
            end
        end
    end

    // RAM is not reset; a write is suppressed while reset is held so an
    // aborted access can never commit.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    assign stall     = r_stall;
    assign wb_data   = r_wb_data;
    assign wb_regdst = r_wb_regdst;
    assign wb_opcode = r_wb_opcode;
    assign wb_en     = r_wb_en;
    assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench; three instances (latency 1, 3, 4) driven
//               by directed and random traffic against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        valid_in      [3];
    logic [31:0] alu_out_in    [3];
    logic [31:0] read_data2_in [3];
    logic [3:0]  opcode_in     [3];
    logic [3:0]  regdst_in     [3];
    logic        stall         [3];
    logic [31:0] wb_data       [3];
    logic [3:0]  wb_regdst     [3];
    logic        wb_en         [3];
    logic [3:0]  wb_opcode     [3];
    logic        misalign      [3];

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %h want %h", nm, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;

        mem_access_stage #(.ADDR_W(8), .MEM_LAT(LAT)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .valid_in     (valid_in[g]),
            .alu_out_in   (alu_out_in[g]),
            .read_data2_in(read_data2_in[g]),
            .opcode_in    (opcode_in[g]),
            .regdst_in    (regdst_in[g]),
            .stall        (stall[g]),
            .wb_data      (wb_data[g]),
            .wb_regdst    (wb_regdst[g]),
            .wb_en        (wb_en[g]),
            .wb_opcode    (wb_opcode[g]),
            .misalign     (misalign[g])
        );

        // Transaction-level model: RAM array, one pending op with an absolute
        // completion cycle, and the expected write-back bundle.
        logic [31:0] m_ram   [256];
        bit          m_known [256];
        bit          pend    = 0;
        int          cyc     = 0;
        int          done_at = 0;
        logic [3:0]  p_op, p_rd;
        logic [31:0] p_a, p_d;
        logic [31:0] e_data  = 0;
        logic [3:0]  e_rd    = 0;
        logic [3:0]  e_op    = 0;
        bit          e_en    = 0;
        bit          e_mis   = 0;
        bit          e_stall = 0;
        bit          e_known = 1;

        task automatic complete(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] rd);
            int idx;
            idx  = int'(a[9:2]);
            e_rd = rd;
            e_op = op;
            if (op == 4'b0100) begin
                e_data  = m_ram[idx];
                e_known = m_known[idx];
                e_en    = 1;
            end else if (op == 4'b0101) begin
                m_ram[idx]   = d;
                m_known[idx] = 1;
            end else if (!(op == 4'b0110 || op == 4'b0111 || op == 4'b1010)) begin
                e_data  = a;
                e_known = 1;
                e_en    = 1;
            end
        endtask

        initial forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                e_data = 0; e_rd = 0; e_op = 0; e_en = 0; e_mis = 0;
                e_stall = 0; e_known = 1; pend = 0;
            end else begin
                e_en  = 0;
                e_mis = 0;
                if (pend) begin
                    if (cyc == done_at) begin
                        pend    = 0;
                        e_stall = 0;
                        complete(p_op, p_a, p_d, p_rd);
                    end
                end else if (valid_in[g]) begin
                    if ((opcode_in[g] == 4'b0100 || opcode_in[g] == 4'b0101) &&
                        alu_out_in[g][1:0] != 2'b00) begin
                        e_mis = 1;
                        e_rd  = regdst_in[g];
                        e_op  = opcode_in[g];
                    end else if ((opcode_in[g] == 4'b0100 || opcode_in[g] == 4'b0101) &&
                                 LAT > 1) begin
                        pend    = 1;
                        done_at = cyc + LAT - 1;
                        e_stall = 1;
                        p_op = opcode_in[g]; p_a = alu_out_in[g];
                        p_d  = read_data2_in[g]; p_rd = regdst_in[g];
                    end else begin
                        complete(opcode_in[g], alu_out_in[g], read_data2_in[g], regdst_in[g]);
                    end
                end
                cyc++;
            end
        end

        initial forever begin
            @(negedge clk);
            if (armed && !rst) begin
                chk("stall", g, 32'(stall[g]), 32'(e_stall));
                chk("wb_en", g, 32'(wb_en[g]), 32'(e_en));
                chk("misalign", g, 32'(misalign[g]), 32'(e_mis));
                chk("wb_regdst", g, 32'(wb_regdst[g]), 32'(e_rd));
                chk("wb_opcode", g, 32'(wb_opcode[g]), 32'(e_op));
                if (e_en && e_known) chk("wb_data", g, wb_data[g], e_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] rd);
        valid_in[i]      = v;
        opcode_in[i]     = op;
        alu_out_in[i]    = a;
        read_data2_in[i] = d;
        regdst_in[i]     = rd;
    endtask

    task automatic idle(input int i);
        put(i, 1'b0, 4'd0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic chk_zero(input int i);
        chk("rst_wb_data", i, wb_data[i], 32'd0);
        chk("rst_wb_regdst", i, 32'(wb_regdst[i]), 32'd0);
        chk("rst_wb_en", i, 32'(wb_en[i]), 32'd0);
        chk("rst_wb_opcode", i, 32'(wb_opcode[i]), 32'd0);
        chk("rst_stall", i, 32'(stall[i]), 32'd0);
        chk("rst_misalign", i, 32'(misalign[i]), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  op;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) idle(i);
        #12;
        for (int i = 0; i < 3; i++) chk_zero(i);
        @(negedge clk);
        rst   = 1'b0;
        armed = 1;
        step();

        // Latency 1: store then load of the same word
        put(0, 1, 4'b0101, 32'h10, 32'hDEADBEEF, 4'd0); step();
        put(0, 1, 4'b0100, 32'h10, 32'd0, 4'd5);       step(); idle(0);
        @(negedge clk);
        chk("ld_data", 0, wb_data[0], 32'hDEADBEEF);
        chk("ld_regdst", 0, 32'(wb_regdst[0]), 32'd5);
        chk("ld_en", 0, 32'(wb_en[0]), 32'd1);
        chk("ld_stall", 0, 32'(stall[0]), 32'd0);
        step();

        // Pass-through, then a branch with no write-back
        put(0, 1, 4'b0000, 32'h12345678, 32'd0, 4'd3); step();
        put(0, 1, 4'b0110, 32'h0000AAAA, 32'd0, 4'd7);
        @(negedge clk);
        chk("pt_data", 0, wb_data[0], 32'h12345678);
        chk("pt_en", 0, 32'(wb_en[0]), 32'd1);
        chk("pt_regdst", 0, 32'(wb_regdst[0]), 32'd3);
        step(); idle(0);
        @(negedge clk);
        chk("br_en", 0, 32'(wb_en[0]), 32'd0);
        chk("br_opcode", 0, 32'(wb_opcode[0]), 32'd6);
        step();

        // Misaligned store leaves memory untouched
        put(0, 1, 4'b0101, 32'h11, 32'h55555555, 4'd2); step(); idle(0);
        @(negedge clk);
        chk("mis_pulse", 0, 32'(misalign[0]), 32'd1);
        chk("mis_en", 0, 32'(wb_en[0]), 32'd0);
        step();
        put(0, 1, 4'b0100, 32'h10, 32'd0, 4'd4); step(); idle(0);
        @(negedge clk);
        chk("mis_keep", 0, wb_data[0], 32'hDEADBEEF);
        step();

        // Address wrap: 0x400 aliases word 0
        put(0, 1, 4'b0101, 32'h400, 32'h0BADF00D, 4'd0); step();
        put(0, 1, 4'b0100, 32'h000, 32'd0, 4'd6);        step(); idle(0);
        @(negedge clk);
        chk("wrap_data", 0, wb_data[0], 32'h0BADF00D);
        step();

        // Latency 3: valid held through the stall must not re-accept
        put(1, 1, 4'b0101, 32'h20, 32'hCAFEF00D, 4'd1); step(); idle(1);
        step(); step();
        put(1, 1, 4'b0100, 32'h20, 32'd0, 4'd9); step();
        @(negedge clk);
        chk("l3_stall_a", 1, 32'(stall[1]), 32'd1);
        chk("l3_en_a", 1, 32'(wb_en[1]), 32'd0);
        step();
        @(negedge clk);
        chk("l3_stall_b", 1, 32'(stall[1]), 32'd1);
        step(); idle(1);
        @(negedge clk);
        chk("l3_stall_c", 1, 32'(stall[1]), 32'd0);
        chk("l3_en_c", 1, 32'(wb_en[1]), 32'd1);
        chk("l3_data", 1, wb_data[1], 32'hCAFEF00D);
        chk("l3_regdst", 1, 32'(wb_regdst[1]), 32'd9);
        step();
        @(negedge clk);
        chk("l3_no_reaccept", 1, 32'(wb_en[1]), 32'd0);
        step();

        // Latency 4: reset in the second wait cycle aborts the store
        put(2, 1, 4'b0101, 32'h30, 32'h11112222, 4'd0); step(); idle(2);
        step(); step(); step();
        put(2, 1, 4'b0101, 32'h30, 32'h99999999, 4'd0); step(); idle(2);
        step();
        #1 rst = 1'b1;
        #1;
        chk_zero(2);
        @(negedge clk);
        rst = 1'b0;
        step();
        put(2, 1, 4'b0100, 32'h30, 32'd0, 4'd8); step(); idle(2);
        step(); step(); step();
        @(negedge clk);
        chk("abort_data", 2, wb_data[2], 32'h11112222);
        chk("abort_en", 2, 32'(wb_en[2]), 32'd1);
        step();

        // Random traffic on all three instances
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                a = $urandom;
                a[9:2] = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
                if ($urandom_range(0, 1) == 1) op = 4'b0100 | 4'($urandom_range(0, 1));
                else op = 4'($urandom_range(0, 15));
                put(i, 1'($urandom_range(0, 9) < 7), op, a, $urandom, 4'($urandom_range(0, 15)));
            end
            step();
        end
        for (int i = 0; i < 3; i++) idle(i);
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
